// File: rtl/gold_pkg.sv
// Shared definitions for the Gold code sequencer: default code geometry and
// the controller state encoding.
package gold_pkg;

   localparam int GOLD_LENGTH   = 63;
   localparam int GOLD_POLY_LEN = $clog2(GOLD_LENGTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/gold_chip_cnt.sv
// Modulo-LENGTH chip counter with enable, synchronous clear and a wrap pulse
// that marks the last chip of each code period.
module gold_chip_cnt #(
   parameter int LENGTH = 63,
   parameter int WIDTH  = 6
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LENGTH - 1);

   assign wrap = en && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/gold_seq_ctrl.sv
// Gold code run controller: accepts a seed/period request, strobes the seed
// load, then enables the generator for the requested number of code periods.
// Optional feature: define GOLD_SEQ_CTRL_STATS_EN to add the stat_periods epoch counter.
module gold_seq_ctrl
   import gold_pkg::*;
#(
   parameter int LENGTH   = GOLD_LENGTH,
   parameter int POLY_LEN = $clog2(LENGTH)
) (
   input  logic                clkin,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [POLY_LEN-1:0] req_seed_a,
   input  logic [POLY_LEN-1:0] req_seed_b,
   input  logic [7:0]          req_periods,
   input  logic                abort,
   output logic                gen_load,
   output logic [POLY_LEN-1:0] gen_seed_a,
   output logic [POLY_LEN-1:0] gen_seed_b,
   output logic                gen_en,
   output logic [POLY_LEN-1:0] chip_idx,
   output logic                epoch,
   output logic                done
`ifdef GOLD_SEQ_CTRL_STATS_EN
   ,
   output logic [15:0]         stat_periods
`endif
);

   localparam logic [POLY_LEN-1:0] SEED_ONE = POLY_LEN'(1);

   state_t     state;
   state_t     next_state;
   logic [7:0] remaining;
   logic       accept;
   logic       cnt_clear;

   assign accept    = (state == IDLE) && req_valid;
   assign req_ready = (state == IDLE);
   assign gen_load  = (state == LOAD);
   assign gen_en    = (state == RUN);
   // Clearing on the exit transition leaves chip_idx at 0 in the first IDLE cycle.
   assign cnt_clear = (next_state != RUN);

   gold_chip_cnt #(
      .LENGTH (LENGTH),
      .WIDTH  (POLY_LEN)
   ) u_chip_cnt (
      .clkin (clkin),
      .rst   (rst),
      .en    (gen_en),
      .clear (cnt_clear),
      .count (chip_idx),
      .wrap  (epoch)
   );

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      done       = 1'b0;
      unique case (state)
         IDLE: if (req_valid) next_state = LOAD;
         LOAD: next_state = abort ? IDLE : RUN;
         RUN: begin
            if (abort) begin
               next_state = IDLE;
            end else if (epoch && (remaining == 8'd1)) begin
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // A zero period count never decrements, which is what makes the run endless.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         remaining  <= 8'd0;
         gen_seed_a <= '0;
         gen_seed_b <= '0;
      end else if (accept) begin
         remaining  <= req_periods;
         gen_seed_a <= (req_seed_a == '0) ? SEED_ONE : req_seed_a;
         gen_seed_b <= (req_seed_b == '0) ? SEED_ONE : req_seed_b;
      end else if (epoch && (remaining != 8'd0)) begin
         remaining  <= remaining - 8'd1;
      end
   end

`ifdef GOLD_SEQ_CTRL_STATS_EN
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         stat_periods <= 16'd0;
      end else if (epoch && (stat_periods != 16'hFFFF)) begin
         stat_periods <= stat_periods + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// Directed self-checking bench for gold_seq_ctrl; all sampling and driving
// happens on the falling clock edge. Honors GOLD_SEQ_CTRL_STATS_EN.
module tb_gold_seq_ctrl;

   logic       clkin = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [5:0] req_seed_a;
   logic [5:0] req_seed_b;
   logic [7:0] req_periods;
   logic       abort;
   logic       gen_load;
   logic [5:0] gen_seed_a;
   logic [5:0] gen_seed_b;
   logic       gen_en;
   logic [5:0] chip_idx;
   logic       epoch;
   logic       done;
`ifdef GOLD_SEQ_CTRL_STATS_EN
   logic [15:0] stat_periods;
`endif

   int checks   = 0;
   int failures = 0;

   // Per-run observations, cycles numbered relative to acceptance (T = 0).
   int cyc, en_cnt, ep_cnt, dn_cnt, ld_cnt;
   int first_en, last_en, last_ep, last_dn, first_rdy;
   int chip_at_first_en, chip_at_ep;

   always #5 clkin = ~clkin;

   gold_seq_ctrl dut (
      .clkin       (clkin),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_seed_a  (req_seed_a),
      .req_seed_b  (req_seed_b),
      .req_periods (req_periods),
      .abort       (abort),
      .gen_load    (gen_load),
      .gen_seed_a  (gen_seed_a),
      .gen_seed_b  (gen_seed_b),
      .gen_en      (gen_en),
      .chip_idx    (chip_idx),
      .epoch       (epoch),
      .done        (done)
`ifdef GOLD_SEQ_CTRL_STATS_EN
      ,
      .stat_periods (stat_periods)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Presents a request in cycle T and steps into T+1, checking the load strobe.
   task automatic accept(input logic [5:0] a, input logic [5:0] b, input logic [7:0] p);
      req_seed_a  = a;
      req_seed_b  = b;
      req_periods = p;
      req_valid   = 1'b1;
      check("accept_ready", 32'(req_ready), 32'd1);
      @(negedge clkin);
      req_valid = 1'b0;
      cyc = 1;
      check("load_strobe", 32'(gen_load), 32'd1);
      check("load_no_en", 32'(gen_en), 32'd0);
   endtask

   task automatic watch(input int ncyc);
      en_cnt = 0; ep_cnt = 0; dn_cnt = 0; ld_cnt = 0;
      first_en = -1; last_en = -1; last_ep = -1; last_dn = -1; first_rdy = -1;
      chip_at_first_en = -1; chip_at_ep = -1;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clkin);
         cyc++;
         if (gen_load) ld_cnt++;
         if (gen_en) begin
            if (first_en < 0) begin
               first_en = cyc;
               chip_at_first_en = int'(chip_idx);
            end
            last_en = cyc;
            en_cnt++;
         end
         if (epoch) begin
            ep_cnt++;
            last_ep = cyc;
            chip_at_ep = int'(chip_idx);
         end
         if (done) begin
            dn_cnt++;
            last_dn = cyc;
         end
         if (req_ready && first_rdy < 0) first_rdy = cyc;
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_seed_a = '0; req_seed_b = '0;
      req_periods = '0; abort = 1'b0;

      // Reset state
      @(negedge clkin);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_load", 32'(gen_load), 32'd0);
      check("rst_en", 32'(gen_en), 32'd0);
      check("rst_seed_a", 32'(gen_seed_a), 32'd0);
      check("rst_seed_b", 32'(gen_seed_b), 32'd0);
      check("rst_chip", 32'(chip_idx), 32'd0);
      check("rst_epoch", 32'(epoch), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clkin);

      // Single period, seeds 01/2A
      accept(6'h01, 6'h2A, 8'd1);
      check("p1_seed_a", 32'(gen_seed_a), 32'h01);
      check("p1_seed_b", 32'(gen_seed_b), 32'h2A);
      check("p1_ready_low", 32'(req_ready), 32'd0);
      watch(70);
      check("p1_load_once", 32'(ld_cnt), 32'd0);
      check("p1_first_en", 32'(first_en), 32'd2);
      check("p1_chip0", 32'(chip_at_first_en), 32'd0);
      check("p1_last_en", 32'(last_en), 32'd64);
      check("p1_en_cnt", 32'(en_cnt), 32'd63);
      check("p1_epochs", 32'(ep_cnt), 32'd1);
      check("p1_epoch_cyc", 32'(last_ep), 32'd64);
      check("p1_epoch_chip", 32'(chip_at_ep), 32'd62);
      check("p1_dones", 32'(dn_cnt), 32'd1);
      check("p1_done_cyc", 32'(last_dn), 32'd64);
      check("p1_ready_cyc", 32'(first_rdy), 32'd65);
      check("p1_idle_chip", 32'(chip_idx), 32'd0);

      // Three periods
      accept(6'h15, 6'h0C, 8'd3);
      watch(200);
      check("p3_en_cnt", 32'(en_cnt), 32'd189);
      check("p3_epochs", 32'(ep_cnt), 32'd3);
      check("p3_dones", 32'(dn_cnt), 32'd1);
      check("p3_done_cyc", 32'(last_dn), 32'd190);
      check("p3_done_with_ep3", 32'(last_ep), 32'd190);
      check("p3_ready_cyc", 32'(first_rdy), 32'd191);

      // Zero-seed substitution, then abort while in LOAD
      accept(6'h00, 6'h3F, 8'd1);
      check("zs_seed_a", 32'(gen_seed_a), 32'h01);
      check("zs_seed_b", 32'(gen_seed_b), 32'h3F);
      abort = 1'b1;
      @(negedge clkin);
      abort = 1'b0;
      check("load_abort_ready", 32'(req_ready), 32'd1);
      check("load_abort_en", 32'(gen_en), 32'd0);

      // Abort in IDLE is ignored
      abort = 1'b1;
      @(negedge clkin);
      abort = 1'b0;
      check("idle_abort_ready", 32'(req_ready), 32'd1);
      check("idle_abort_load", 32'(gen_load), 32'd0);

      // Abort at chip_idx 10
      accept(6'h07, 6'h09, 8'd2);
      dn_cnt = 0;
      for (int i = 0; i < 200 && !(gen_en && chip_idx == 6'd10); i++) begin
         @(negedge clkin);
         if (done) dn_cnt++;
      end
      check("ab10_reached", 32'(gen_en && chip_idx == 6'd10), 32'd1);
      abort = 1'b1;
      @(negedge clkin);
      abort = 1'b0;
      check("ab10_en", 32'(gen_en), 32'd0);
      check("ab10_ready", 32'(req_ready), 32'd1);
      check("ab10_chip", 32'(chip_idx), 32'd0);
      check("ab10_no_done", 32'(dn_cnt + int'(done)), 32'd0);

      // Abort coincident with the final epoch
      accept(6'h11, 6'h22, 8'd1);
      for (int i = 0; i < 200 && !(gen_en && chip_idx == 6'd62); i++) @(negedge clkin);
      check("abep_reached", 32'(gen_en && chip_idx == 6'd62), 32'd1);
      abort = 1'b1;
      #1;
      check("abep_epoch", 32'(epoch), 32'd1);
      check("abep_no_done", 32'(done), 32'd0);
      @(negedge clkin);
      abort = 1'b0;
      check("abep_ready", 32'(req_ready), 32'd1);
      check("abep_en", 32'(gen_en), 32'd0);

      // Asynchronous reset mid-run at chip_idx 30
      accept(6'h05, 6'h06, 8'd2);
      for (int i = 0; i < 200 && !(gen_en && chip_idx == 6'd30); i++) @(negedge clkin);
      check("rst30_reached", 32'(gen_en && chip_idx == 6'd30), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst30_ready", 32'(req_ready), 32'd1);
      check("rst30_en", 32'(gen_en), 32'd0);
      check("rst30_load", 32'(gen_load), 32'd0);
      check("rst30_chip", 32'(chip_idx), 32'd0);
      check("rst30_seed_a", 32'(gen_seed_a), 32'd0);
      check("rst30_seed_b", 32'(gen_seed_b), 32'd0);
      check("rst30_epoch", 32'(epoch), 32'd0);
      check("rst30_done", 32'(done), 32'd0);
      @(negedge clkin);
      rst = 1'b0;
      @(negedge clkin);

      // Endless run: five epochs, then abort
      accept(6'h2B, 6'h19, 8'd0);
      ep_cnt = 0;
      dn_cnt = 0;
      for (int i = 0; i < 400 && ep_cnt < 5; i++) begin
         @(negedge clkin);
         if (epoch) ep_cnt++;
         if (done) dn_cnt++;
      end
      check("inf_epochs", 32'(ep_cnt), 32'd5);
      @(negedge clkin);
      check("inf_still_run", 32'(gen_en), 32'd1);
      abort = 1'b1;
      @(negedge clkin);
      abort = 1'b0;
      check("inf_ready", 32'(req_ready), 32'd1);
      check("inf_no_done", 32'(dn_cnt), 32'd0);
`ifdef GOLD_SEQ_CTRL_STATS_EN
      check("inf_stat_periods", 32'(stat_periods), 32'd5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gold_seq_ctrl.md
GOLD_SEQ_CTRL -- requirements
Module: gold_seq_ctrl

Interface
REQ-001 SHALL have parameter LENGTH, default 63, Gold code period in chips.
REQ-002 SHALL have parameter POLY_LEN, default $clog2(LENGTH) (6), LFSR width.
REQ-003 SHALL have port clkin, input, 1, single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, code-run request valid.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_seed_a, input, POLY_LEN, seed for LFSR A.
REQ-008 SHALL have port req_seed_b, input, POLY_LEN, seed for LFSR B.
REQ-009 SHALL have port req_periods, input, 8, number of code periods; 0 means run until abort.
REQ-010 SHALL have port abort, input, 1, terminate the current run.
REQ-011 SHALL have port gen_load, output, 1, one-cycle seed-load strobe to the generator.
REQ-012 SHALL have port gen_seed_a, output, POLY_LEN, registered seed A.
REQ-013 SHALL have port gen_seed_b, output, POLY_LEN, registered seed B.
REQ-014 SHALL have port gen_en, output, 1, generator chip-advance enable.
REQ-015 SHALL have port chip_idx, output, POLY_LEN, current chip index 0..LENGTH-1.
REQ-016 SHALL have port epoch, output, 1, pulse on the last chip of each period.
REQ-017 SHALL have port done, output, 1, pulse on normal completion.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN; req_ready=1 only in IDLE.
REQ-019 SHALL, on acceptance in cycle T, register seeds and periods and enter LOAD at T+1 with gen_load=1 for exactly one cycle.
REQ-020 SHALL enter RUN at T+2 with gen_en=1 and chip_idx=0; chip_idx increments every RUN cycle and wraps LENGTH-1 -> 0.
REQ-021 SHALL assert epoch for one cycle whenever chip_idx==LENGTH-1 in RUN.
REQ-022 SHALL decrement the remaining-period count on each epoch when req_periods was nonzero.
REQ-023 SHALL assert done with the final epoch and return to IDLE the next cycle (gen_en=0, chip_idx=0).
REQ-024 SHALL run indefinitely with req_periods=0, never asserting done.
REQ-025 SHALL replace an all-zero seed with 1 (LSB set) on gen_seed_a/gen_seed_b; nonzero seeds pass unchanged.
REQ-026 SHALL, on abort in LOAD or RUN, return to IDLE next cycle with gen_en=0 and no done; abort in IDLE is ignored.
REQ-027 SHALL give abort priority over a coincident final epoch: epoch still pulses, done does not.
REQ-028 SHALL ignore req_valid outside IDLE; a request held valid through IDLE is accepted on the first IDLE cycle.

Reset
REQ-029 SHALL, on rst asserted, asynchronously force IDLE, req_ready=1, gen_load=0, gen_en=0, gen_seed_a=gen_seed_b=0, chip_idx=0, epoch=0, done=0, counters 0.
REQ-030 SHALL, when rst asserts mid-run, abandon the run with no done pulse.

Configuration
REQ-031 SHALL, with GOLD_SEQ_CTRL_STATS_EN defined, add output stat_periods (16 bits), counting every epoch, saturating at 16'hFFFF, cleared only by rst.
REQ-032 SHALL, without GOLD_SEQ_CTRL_STATS_EN, omit the port and counter entirely.

Structure
REQ-033 SHALL place LENGTH/POLY_LEN defaults and the state enum in shared package gold_pkg.
REQ-034 SHALL instantiate sub-module gold_chip_cnt (mod-LENGTH counter with enable, clear, wrap pulse) for chip_idx/epoch.

Verification
REQ-035 SHALL verify: seeds 6'h01/6'h2A, periods=1 accepted at T -> gen_load at T+1, gen_en T+2..T+64 (63 cycles), epoch+done at T+64, req_ready=1 at T+65.
REQ-036 SHALL verify: periods=3 -> 189 gen_en cycles, 3 epochs, 1 done coincident with the third epoch.
REQ-037 SHALL verify: seed_a=0, seed_b=6'h3F -> gen_seed_a=6'h01, gen_seed_b=6'h3F.
REQ-038 SHALL verify: abort at chip_idx=10 -> gen_en=0 and IDLE next cycle, done never asserted; abort coincident with final epoch -> no done.
REQ-039 SHALL verify: periods=0 runs 5 epochs then abort -> no done; with GOLD_SEQ_CTRL_STATS_EN stat_periods=5.
REQ-040 SHALL verify: rst asserted at chip_idx=30 -> all outputs at reset values without waiting for a clkin edge.
